// File: rtl/io_timer_intc_pkg.sv
// Shared definitions for the IO timer / interrupt requester: register map,
// control/status bit positions and handshake FSM encodings.
package io_defs;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_PEND = 0;
    localparam int STAT_OVF  = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/io_timer_intc_if.sv
// CPU IO-bus view of the timer peripheral: select/strobes, address, data and
// the intr/inta interrupt handshake.
interface io_timer_intc_if;

    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_address;
    logic [31:0] io_d_in;
    logic [31:0] io_out;
    logic        intr;
    logic        inta;

    modport master (
        output io_cs, io_rd, io_wr, io_address, io_d_in, inta,
        input  io_out, intr
    );

    modport slave (
        input  io_cs, io_rd, io_wr, io_address, io_d_in, inta,
        output io_out, intr
    );

endinterface

// File: rtl/io_timer_intc_handshake.sv
// Interrupt request FSM: raises intr while PEND&IE, clears PEND when the CPU
// acknowledges, and waits for inta to drop before re-requesting.
module io_intr_handshake
    import io_defs::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pend,
    input  logic ie,
    input  logic inta,
    output logic intr,
    output logic ack_clr
);

    logic [1:0] state_q, state_d;
    logic       intr_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every output - no latches.
        state_d = state_q;
        ack_clr = 1'b0;
        case (state_q)
            ST_IDLE: if (pend && ie) state_d = ST_REQ;
            ST_REQ: begin
                if (inta) begin
                    state_d = ST_ACK;
                    ack_clr = 1'b1;
                end else if (!(pend && ie)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  if (!inta) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            intr_q  <= (state_d == ST_REQ);
        end
    end

    assign intr = intr_q;

endmodule

// File: rtl/io_timer_intc.sv
// Memory-mapped prescaled countdown timer with an interrupt requester feeding
// the CPU intr/inta handshake.
module io_timer_intc
    import io_defs::*;
#(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 32
) (
    input  logic           clk,
    input  logic           reset,
    io_timer_intc_if.slave bus
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
    logic             pend_q, pend_d, ovf_q, ovf_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [31:0]      rdata;
    logic [2:0]       idx;
    logic             wr_en, rd_en, wr_ctrl, wr_load, wr_count, wr_status;
    logic             tick, expire, ack_clr, intr;
    logic             unused_addr;

    assign idx         = bus.io_address[4:2];
    assign unused_addr = ^{bus.io_address[31:5], bus.io_address[1:0]};
    assign wr_en       = bus.io_cs & bus.io_wr;
    assign rd_en       = bus.io_cs & bus.io_rd;
    assign wr_ctrl     = wr_en && (idx == REG_CTRL);
    assign wr_load     = wr_en && (idx == REG_LOAD);
    assign wr_count    = wr_en && (idx == REG_COUNT);
    assign wr_status   = wr_en && (idx == REG_STATUS);

    // A CPU write to COUNT or CTRL swallows a tick landing in the same cycle.
    assign tick   = ctrl_q[CTRL_EN] && (presc_q == PRESC_LAST) && !(wr_ctrl || wr_count);
    assign expire = tick && (count_q == '0);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (!ctrl_q[CTRL_EN] || wr_ctrl || wr_count || presc_q == PRESC_LAST) presc_d = '0;

        count_d = count_q;
        if (wr_count) begin
            count_d = bus.io_d_in[CNT_W-1:0];
        end else if (tick) begin
            if (count_q != '0)         count_d = count_q - CNT_W'(1);
            else if (ctrl_q[CTRL_AUTO]) count_d = load_q;
        end

        ctrl_d = ctrl_q;
        if (wr_ctrl)                               ctrl_d = bus.io_d_in[2:0];
        else if (expire && !ctrl_q[CTRL_AUTO])     ctrl_d[CTRL_EN] = 1'b0;

        load_d = wr_load ? bus.io_d_in[CNT_W-1:0] : load_q;

        // Clears first, expiry last: a fresh expiry always leaves PEND set.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (wr_status && bus.io_d_in[STAT_PEND]) pend_d = 1'b0;
        if (wr_status && bus.io_d_in[STAT_OVF])  ovf_d  = 1'b0;
        if (ack_clr)                             pend_d = 1'b0;
        if (expire) begin
            pend_d = 1'b1;
            if (pend_q) ovf_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (idx)
                REG_CTRL:   rdata = 32'(ctrl_q);
                REG_LOAD:   rdata = 32'(load_q);
                REG_COUNT:  rdata = 32'(count_q);
                REG_STATUS: rdata = 32'({ovf_q, pend_q});
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
        end
    end

    io_intr_handshake u_handshake (
        .clk     (clk),
        .reset   (reset),
        .pend    (pend_q),
        .ie      (ctrl_q[CTRL_IE]),
        .inta    (bus.inta),
        .intr    (intr),
        .ack_clr (ack_clr)
    );

    assign bus.io_out = rdata;
    assign bus.intr   = intr;

endmodule

// File: tb/tb_io_timer_intc.sv
// Self-checking bench for io_timer_intc: register table, timer period, one-shot,
// overflow, interrupt handshake and same-cycle write/tick corner cases.
module tb_io_timer_intc;
    import io_defs::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    io_timer_intc_if bus();

    io_timer_intc #(.PRESCALE(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        bit          do_wr;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        bus.io_cs      = 1'b1;
        bus.io_wr      = 1'b1;
        bus.io_address = {27'd0, idx, 2'b00};
        bus.io_d_in    = data;
        @(negedge clk);
        bus.io_cs = 1'b0;
        bus.io_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
        sb_t e;
        sb_q.push_back('{name, exp});
        bus.io_cs      = 1'b1;
        bus.io_rd      = 1'b1;
        bus.io_address = {27'd0, idx, 2'b00};
        #1;
        e = sb_q.pop_front();
        check(e.name, bus.io_out, e.exp);
        bus.io_cs = 1'b0;
        bus.io_rd = 1'b0;
    endtask

    task automatic rdwr(input logic [2:0] idx, input logic [31:0] data,
                        input logic [31:0] exp, input string name);
        sb_t e;
        sb_q.push_back('{name, exp});
        bus.io_cs      = 1'b1;
        bus.io_rd      = 1'b1;
        bus.io_wr      = 1'b1;
        bus.io_address = {27'd0, idx, 2'b00};
        bus.io_d_in    = data;
        #1;
        e = sb_q.pop_front();
        check(e.name, bus.io_out, e.exp);
        @(negedge clk);
        bus.io_cs = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
    endtask

    task automatic chk_intr(input logic exp, input string name);
        check(name, {31'd0, bus.intr}, {31'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.io_cs      = 1'b0;
        bus.io_rd      = 1'b0;
        bus.io_wr      = 1'b0;
        bus.io_address = '0;
        bus.io_d_in    = '0;
        bus.inta       = 1'b0;
        cycles(3);
        chk_intr(1'b0, "intr_in_reset");
        reset = 1'b0;
        cycles(1);

        // Reset values, decode, write masking and W1C on a clear register.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b0, 3'(i), 32'h0, 32'h0, $sformatf("reset_reg%0d", i)});
        vecs.push_back('{1'b1, REG_CTRL,   32'hFFFF_FFF8, 32'h0,         "ctrl_high_bits"});
        vecs.push_back('{1'b1, REG_LOAD,   32'hDEAD_BEEF, 32'hDEAD_BEEF, "load_rw"});
        vecs.push_back('{1'b1, REG_COUNT,  32'h1234_5678, 32'h1234_5678, "count_rw"});
        vecs.push_back('{1'b1, 3'd5,       32'hFFFF_FFFF, 32'h0,         "reg5_ignored"});
        vecs.push_back('{1'b1, REG_STATUS, 32'h3,         32'h0,         "status_w1c_idle"});
        vecs.push_back('{1'b1, REG_CTRL,   32'h6,         32'h6,         "ctrl_auto_ie"});
        vecs.push_back('{1'b1, REG_CTRL,   32'h0,         32'h0,         "ctrl_off"});
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].idx, vecs[i].wdata);
            rd(vecs[i].idx, vecs[i].exp, vecs[i].name);
        end
        check("io_out_unselected", bus.io_out, 32'h0);
        chk_intr(1'b0, "intr_after_reset");
        bus.inta = 1'b1;
        cycles(3);
        chk_intr(1'b0, "inta_in_idle");
        bus.inta = 1'b0;

        // Auto-reload period (LOAD+1)*PRESCALE = 16 with IE set.
        wr(REG_COUNT, 32'd3);
        wr(REG_LOAD, 32'd3);
        wr(REG_CTRL, 32'h7);
        cycles(15);
        rd(REG_STATUS, 32'h0, "t2_no_pend_15");
        rd(REG_COUNT, 32'h0, "t2_count_15");
        cycles(1);
        rd(REG_STATUS, 32'h1, "t2_pend_16");
        rd(REG_COUNT, 32'h3, "t2_reload");
        chk_intr(1'b0, "t2_intr_16");
        cycles(1);
        chk_intr(1'b1, "t2_intr_17");
        cycles(3);
        rd(REG_COUNT, 32'h2, "t2_count_20");

        // Acknowledge; a second expiry while inta is held waits for inta low.
        bus.inta = 1'b1;
        cycles(1);
        chk_intr(1'b0, "t3_intr_ack");
        rd(REG_STATUS, 32'h0, "t3_pend_ack_clr");
        cycles(11);
        rd(REG_STATUS, 32'h1, "t3_pend_in_ack");
        chk_intr(1'b0, "t3_intr_in_ack");
        cycles(2);
        chk_intr(1'b0, "t3_intr_inta_held");
        bus.inta = 1'b0;
        cycles(1);
        chk_intr(1'b0, "t3_intr_ack_idle");
        cycles(1);
        chk_intr(1'b1, "t3_intr_rereq");

        // Synchronous reset while in REQ.
        reset = 1'b1;
        cycles(1);
        chk_intr(1'b0, "t1_reset_in_req");
        reset = 1'b0;
        rd(REG_CTRL, 32'h0, "t1_ctrl_after_rst");
        rd(REG_STATUS, 32'h0, "t1_status_after_rst");
        cycles(2);
        chk_intr(1'b0, "t1_fsm_idle");

        // One-shot: single expiry after 12 cycles, EN cleared.
        wr(REG_COUNT, 32'd2);
        wr(REG_LOAD, 32'd2);
        wr(REG_CTRL, 32'h5);
        cycles(11);
        rd(REG_STATUS, 32'h0, "t4_no_pend_11");
        rd(REG_CTRL, 32'h5, "t4_ctrl_running");
        cycles(1);
        rd(REG_STATUS, 32'h1, "t4_pend_12");
        rd(REG_CTRL, 32'h4, "t4_en_cleared");
        rd(REG_COUNT, 32'h0, "t4_count_stays");
        cycles(1);
        chk_intr(1'b1, "t4_intr");
        cycles(20);
        rd(REG_STATUS, 32'h1, "t4_no_refire");
        rd(REG_COUNT, 32'h0, "t4_count_still0");
        wr(REG_STATUS, 32'h1);
        chk_intr(1'b1, "t4_intr_w1c_edge");
        cycles(1);
        chk_intr(1'b0, "t4_intr_sw_clear");
        rd(REG_STATUS, 32'h0, "t4_status_clear");

        // IE off: two expiries give PEND and OVF, then W1C each bit.
        wr(REG_LOAD, 32'd1);
        wr(REG_COUNT, 32'd1);
        wr(REG_CTRL, 32'h3);
        cycles(16);
        rd(REG_STATUS, 32'h3, "t5_pend_ovf");
        chk_intr(1'b0, "t5_intr_ie_off");
        wr(REG_CTRL, 32'h0);
        wr(REG_STATUS, 32'h0);
        rd(REG_STATUS, 32'h3, "t5_w0_noop");
        wr(REG_STATUS, 32'h1);
        rd(REG_STATUS, 32'h2, "t5_clr_pend");
        wr(REG_STATUS, 32'h2);
        rd(REG_STATUS, 32'h0, "t5_clr_ovf");

        // COUNT write on a tick cycle wins and restarts the prescaler.
        wr(REG_COUNT, 32'd9);
        wr(REG_LOAD, 32'd9);
        wr(REG_CTRL, 32'h3);
        cycles(3);
        wr(REG_COUNT, 32'd5);
        rd(REG_COUNT, 32'd5, "t6_write_wins");
        cycles(3);
        rd(REG_COUNT, 32'd5, "t6_presc_restart");
        cycles(1);
        rd(REG_COUNT, 32'd4, "t6_next_tick");
        cycles(19);
        wr(REG_STATUS, 32'h1);
        rd(REG_STATUS, 32'h1, "t6_expiry_beats_w1c");
        rd(REG_COUNT, 32'd9, "t6_reload");

        // Read and write together returns the pre-write value.
        rdwr(REG_LOAD, 32'd7, 32'd9, "rdwr_old_value");
        rd(REG_LOAD, 32'd7, "rdwr_new_value");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_timer_intc.md
Name: io_timer_intc

Overview:
- Memory-mapped I/O peripheral on the CPU's IO bus: a prescaled countdown timer plus the interrupt requester that drives the CPU `intr` input.
- Directly upstream of MIPS_CPU's interrupt path.
- Shares `dm_address` / `dm_d_in` with data memory, selected by `io_cs`.
- Produces `io_out` for CPU loads and runs the `intr`/`inta` handshake the CPU's interrupt sequence consumes.

Parameters:
- PRESCALE, 4: clock cycles per timer tick; legal range ≥1.
- CNT_W, 32: width of the LOAD and COUNT registers; 32 maximum.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_cs  in  1  peripheral select.
- io_rd  in  1  read strobe, qualified by io_cs.
- io_wr  in  1  write strobe, qualified by io_cs.
- io_address  in  32  byte address; only [4:2] are decoded.
- io_d_in  in  32  write data from the CPU.
- io_out  out  32  read data to the CPU.
- intr  out  1  interrupt request to the CPU.
- inta  in  1  interrupt acknowledge from the CPU.

Behaviour:
- Register map (word index = io_address[4:2]):
  - 0 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable).
  - 1 LOAD, R/W.
  - 2 COUNT: a write loads the counter; a read returns the live count.
  - 3 STATUS: bit0 PEND, bit1 OVF. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 4-7: read 0; writes ignored.
- Read:
  - io_out = selected register when io_cs&io_rd; otherwise 32'h0.
  - Combinational, zero-latency; matches the data memory read timing.
  - Unused high bits read 0.
- Write:
  - Takes effect on the clock edge where io_cs&io_wr.
  - io_rd and io_wr together: write occurs, and the read returns the pre-write value.
- Reset values:
  - CTRL, LOAD, COUNT, STATUS = 0.
  - Prescaler = 0, FSM = IDLE.
  - intr = 0, io_out = 0.
  - Reset mid-handshake drops intr on the next edge.
- Prescaler:
  - While EN=1, counts 0..PRESCALE-1; a tick is issued on the cycle it equals PRESCALE-1, then it wraps to 0.
  - EN=0 holds the prescaler at 0.
  - Any write to COUNT or CTRL clears the prescaler.
- Counter, per tick:
  - COUNT≠0: decrement.
  - COUNT==0, AUTO=1: set PEND; if PEND was already 1, also set OVF. Then COUNT←LOAD.
  - COUNT==0, AUTO=0: same PEND/OVF update, COUNT stays 0, and EN is cleared (one-shot).
  - Period = (LOAD+1)×PRESCALE cycles.
- Simultaneous events:
  - CPU write to COUNT/CTRL in the same cycle as a tick: the write wins and the tick is discarded.
  - Expiry in the same cycle as a W1C of PEND: PEND stays set.
- Interrupt FSM, states IDLE, REQ, ACK:
  - IDLE→REQ when PEND&IE; intr=1 from the next cycle.
  - REQ→ACK when inta=1. intr=0 and PEND cleared on that edge; this clear takes priority over a W1C.
  - REQ→IDLE if software clears PEND or IE before inta; intr drops.
  - ACK→IDLE when inta=0. A new PEND that arrives during ACK is re-requested only after inta returns low.
  - intr is registered, equal to (state==REQ).
  - inta while IDLE is ignored.
- Counter width: arithmetic is CNT_W bits; no underflow is possible because decrement occurs only on COUNT≠0.

Decomposition:
- Shared package/header `io_defs`:
  - Register indices CTRL=0, LOAD=1, COUNT=2, STATUS=3.
  - CTRL bit positions EN/AUTO/IE; STATUS bit positions PEND/OVF.
  - FSM state encodings IDLE=2'd0, REQ=2'd1, ACK=2'd2.
- Sub-module `io_intr_handshake`:
  - Owns the FSM and the intr register.
  - Inputs: pend, ie, inta. Outputs: intr, ack_clr (single-cycle pulse that clears PEND).
- Timer, prescaler and register decode remain in the top.

Test Plan:
1. Reset, then read regs 0-7 → all 0, intr=0. Assert reset during REQ → intr=0 next edge, FSM IDLE.
2. Write LOAD=3, CTRL=3'b111, PRESCALE=4 → PEND at cycle 16 after the CTRL write. intr rises on the next edge; COUNT reloads to 3; period 16 repeats.
3. In REQ, drive inta high one cycle then low → intr=0 and PEND=0 on that edge. A second expiry while inta is held high → intr re-asserts only after inta=0.
4. AUTO=0, LOAD=2 → one expiry after 12 cycles. CTRL reads 3'b100 (EN cleared); COUNT stays 0; no further PEND.
5. IE=0, let the timer expire twice → STATUS=2'b11, intr=0. Write STATUS=1 → STATUS=2'b10. Write 2 → STATUS=0.
6. Write COUNT=5 on the exact tick cycle → COUNT reads 5, not 4, and the prescaler restarts. Write PEND-clear on the expiry cycle → PEND remains 1.
